iot_monitor_multi: RTL

- Multi-channel successor to the single-input active-device monitor: tracks the number of active IoT devices reported over CHANNELS independent change/on_off lanes.
- All lanes are summed into one up/down occupancy counter.
- Adds parametrised width, selectable saturate/wrap arithmetic, sticky overflow/underflow flags, a synchronous clear, and a threshold alarm with hysteresis.
- Sits between the device-event front end and the status/LED reporting logic.

---
 rtl/iot_monitor_multi.sv | 116 +++++++++++
 1 files changed

// File: rtl/iot_monitor_multi.sv
// Multi-lane active-device occupancy counter with saturate/wrap arithmetic,
// sticky bound flags, synchronous clear and hysteretic alarm.
// Optional peak tracking is compiled in with `define MONITOR_PEAK_EN.
module iot_monitor_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int WRAP      = 0,
  parameter int THRESHOLD = 200,
  parameter int HYST      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] change,
  input  logic [CHANNELS-1:0] on_off,
  input  logic                clear,
  output logic [WIDTH-1:0]    counter_out,
  output logic                alarm,
  output logic                ovf,
  output logic                unf
`ifdef MONITOR_PEAK_EN
  ,
  output logic [WIDTH-1:0]    peak_out
`endif
);

  localparam int CW = $clog2(CHANNELS + 1);
  localparam int SW = WIDTH + $clog2(CHANNELS) + 2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] REL     = WIDTH'(THRESHOLD - HYST);

  typedef enum logic {IDLE, ACTIVE} alarm_state_e;

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  alarm_state_e         state_q;
  logic [CW-1:0]        ups, downs;
  logic signed [SW-1:0] sum_s;
  logic                 ovf_hit, unf_hit;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; clocked blocks use only '<='.
  always_comb begin
    ups   = '0;
    downs = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ups   = ups   + CW'(change[i] &  on_off[i]);
      downs = downs + CW'(change[i] & ~on_off[i]);
    end
  end

  // Wide signed sum: the sign bit flags underflow, any bit above WIDTH overflow.
  always_comb begin
    sum_s   = $signed(SW'(count_q)) + $signed(SW'(ups)) - $signed(SW'(downs));
    unf_hit = sum_s[SW-1];
    ovf_hit = ~sum_s[SW-1] & (|sum_s[SW-2:WIDTH]);

    if (WRAP != 0)    count_d = sum_s[WIDTH-1:0];
    else if (ovf_hit) count_d = CNT_MAX;
    else if (unf_hit) count_d = '0;
    else              count_d = sum_s[WIDTH-1:0];
    ovf_d = ovf_q | ovf_hit;
    unf_d = unf_q | unf_hit;

    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
  end

  // Alarm state is judged on the value the counter is about to take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (clear) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    if (count_d >= THR) state_q <= ACTIVE;
          ACTIVE:  if (count_d <  REL) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign counter_out = count_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign alarm       = (state_q == ACTIVE);

`ifdef MONITOR_PEAK_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 peak_q <= '0;
    else if (clear)           peak_q <= '0;
    else if (count_d > peak_q) peak_q <= count_d;
  end

  assign peak_out = peak_q;
`else
  // Peak tracking not built.
`endif

endmodule
